// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
// Shared definitions for the run-control stage: the FSM state encoding and
// the program-counter width used for the retire stream and halt_pc capture.
package run_ctrl_pkg;

    localparam int PC_W = 16;

    // Encoding is fixed so that state values are stable across tools and
    // recognisable when probed during bring-up.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } run_state_e;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock, all updates on rising edge
//   rst_n - synchronous active-low reset, count returns to 0
//   clr   - synchronous clear, takes priority over en
//   en    - advance the count by one this cycle
//   count - current count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over enable; an enabled count at all-ones holds its value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl
// Run-control stage in front of the simulation clock generator. Watches the
// writeback retire stream for a HALT, freezes the front end while memory
// drains, then raises halt. A cycle-limit watchdog forces a timeout halt if
// no HALT retires in time. Cycle, retire and halt-PC statistics are exposed
// for end-of-run reporting.
// Ports:
//   clk          - single clock
//   rst_n        - synchronous active-low reset
//   wb_valid     - an instruction retires this cycle
//   wb_halt      - retiring instruction is HALT (qualified by wb_valid)
//   wb_pc        - PC of the retiring instruction
//   mem_idle     - no outstanding memory writes
//   freeze       - stall fetch/decode (DRAIN, DONE, TIMEOUT)
//   halt         - stop request to the clock generator (DONE, TIMEOUT)
//   timed_out    - run ended by the watchdog
//   cycle_count  - cycles spent in RUN plus DRAIN
//   retire_count - instructions retired in RUN, including HALT
//   halt_pc      - PC of the HALT that ended the run
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = 10000,
    parameter int DRAIN_MAX  = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic             wb_halt,
    input  logic [PC_W-1:0]  wb_pc,
    input  logic             mem_idle,
    output logic             freeze,
    output logic             halt,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [PC_W-1:0]  halt_pc
);

    // One spare bit so the drain counter can always represent DRAIN_MAX-1.
    localparam int DRAIN_W = $clog2(DRAIN_MAX) + 1;

    run_state_e       state_q;
    run_state_e       state_d;
    logic [PC_W-1:0]  halt_pc_q;
    logic [PC_W-1:0]  halt_pc_d;

    logic             cycle_en;
    logic             retire_en;
    logic             drain_clr;
    logic             drain_en;
    logic [DRAIN_W-1:0] drain_count;

    // Counter values widened to 32 bits so the limit comparisons never
    // alias through truncation when a counter is narrower than the limit.
    logic [31:0]      cycle_ext;
    logic [31:0]      drain_ext;

    assign cycle_ext = 32'(cycle_count);
    assign drain_ext = 32'(drain_count);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (cycle_en),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (retire_en),
        .count (retire_count)
    );

    sat_counter #(.W(DRAIN_W)) u_drain_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (drain_clr),
        .en    (drain_en),
        .count (drain_count)
    );

    // Next-state and counter-enable decode. A retiring HALT is checked
    // before the watchdog so HALT wins when both happen on the same cycle.
    // The watchdog is only evaluated in RUN; DRAIN always completes.
    always_comb begin
        state_d   = state_q;
        halt_pc_d = halt_pc_q;
        cycle_en  = 1'b0;
        retire_en = 1'b0;
        drain_clr = 1'b0;
        drain_en  = 1'b0;
        case (state_q)
            RUN: begin
                cycle_en  = 1'b1;
                retire_en = wb_valid;
                if (wb_valid && wb_halt) begin
                    halt_pc_d = wb_pc;
                    drain_clr = 1'b1;
                    state_d   = DRAIN;
                end else if (cycle_ext == 32'(MAX_CYCLES - 1)) begin
                    state_d = TIMEOUT;
                end
            end
            DRAIN: begin
                cycle_en = 1'b1;
                drain_en = 1'b1;
                if (mem_idle || (drain_ext == 32'(DRAIN_MAX - 1))) begin
                    state_d = DONE;
                end
            end
            default: begin
                // DONE and TIMEOUT are terminal until reset.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            halt_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    // Status outputs are pure decodes of the registered state.
    assign freeze    = (state_q != RUN);
    assign halt      = (state_q == DONE) || (state_q == TIMEOUT);
    assign timed_out = (state_q == TIMEOUT);
    assign halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl
// Directed testbench for run_ctrl. dut_a runs with a short watchdog
// (MAX_CYCLES=20) and 16-bit counters; dut_b shares the same inputs but
// uses 4-bit counters to exercise saturation.
module tb_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_halt;
    logic [15:0] wb_pc;
    logic        mem_idle;

    logic        a_freeze;
    logic        a_halt;
    logic        a_timed_out;
    logic [15:0] a_cycle_count;
    logic [15:0] a_retire_count;
    logic [15:0] a_halt_pc;

    logic        b_freeze;
    logic        b_halt;
    logic        b_timed_out;
    logic [3:0]  b_cycle_count;
    logic [3:0]  b_retire_count;
    logic [15:0] b_halt_pc;

    int checks = 0;
    int errors = 0;

    run_ctrl #(.MAX_CYCLES(20), .DRAIN_MAX(16), .CNT_W(16)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_halt      (wb_halt),
        .wb_pc        (wb_pc),
        .mem_idle     (mem_idle),
        .freeze       (a_freeze),
        .halt         (a_halt),
        .timed_out    (a_timed_out),
        .cycle_count  (a_cycle_count),
        .retire_count (a_retire_count),
        .halt_pc      (a_halt_pc)
    );

    run_ctrl #(.MAX_CYCLES(100), .DRAIN_MAX(16), .CNT_W(4)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_halt      (wb_halt),
        .wb_pc        (wb_pc),
        .mem_idle     (mem_idle),
        .freeze       (b_freeze),
        .halt         (b_halt),
        .timed_out    (b_timed_out),
        .cycle_count  (b_cycle_count),
        .retire_count (b_retire_count),
        .halt_pc      (b_halt_pc)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge pass, then settle so
    // outputs are sampled away from the edge.
    task automatic applyStimulus(input logic v, input logic h,
                                 input logic [15:0] pc, input logic idle);
        wb_valid = v;
        wb_halt  = h;
        wb_pc    = pc;
        mem_idle = idle;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_freeze"}, 32'(a_freeze), 32'd0);
        checkOutput({tag, "_halt"}, 32'(a_halt), 32'd0);
        checkOutput({tag, "_timed_out"}, 32'(a_timed_out), 32'd0);
        checkOutput({tag, "_cycle"}, 32'(a_cycle_count), 32'd0);
        checkOutput({tag, "_retire"}, 32'(a_retire_count), 32'd0);
        checkOutput({tag, "_halt_pc"}, 32'(a_halt_pc), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_valid = 1'b0;
        wb_halt  = 1'b0;
        wb_pc    = 16'h0000;
        mem_idle = 1'b0;

        // Reset state.
        doReset();
        checkCleared("reset");

        // Three idle cycles, then HALT at 0x0010 with memory already idle.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0010, 1'b0);
        checkOutput("t1_drain_freeze", 32'(a_freeze), 32'd1);
        checkOutput("t1_drain_halt", 32'(a_halt), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("t1_done_halt", 32'(a_halt), 32'd1);
        checkOutput("t1_halt_pc", 32'(a_halt_pc), 32'h0010);
        checkOutput("t1_retire", 32'(a_retire_count), 32'd1);
        checkOutput("t1_timed_out", 32'(a_timed_out), 32'd0);
        checkOutput("t1_cycle", 32'(a_cycle_count), 32'd5);
        applyStimulus(1'b1, 1'b1, 16'h0055, 1'b1);
        checkOutput("t1_frozen_retire", 32'(a_retire_count), 32'd1);
        checkOutput("t1_frozen_cycle", 32'(a_cycle_count), 32'd5);
        checkOutput("t1_frozen_pc", 32'(a_halt_pc), 32'h0010);

        // Five retires then HALT, memory never idle: forced after DRAIN_MAX.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'(i * 4), 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0100, 1'b0);
        checkOutput("t2_retire_at_halt", 32'(a_retire_count), 32'd6);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0200, 1'b0);
            checkOutput("t2_drain_freeze", 32'(a_freeze), 32'd1);
            checkOutput("t2_drain_halt", 32'(a_halt), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("t2_done_halt", 32'(a_halt), 32'd1);
        checkOutput("t2_retire", 32'(a_retire_count), 32'd6);
        checkOutput("t2_halt_pc", 32'(a_halt_pc), 32'h0100);
        checkOutput("t2_timed_out", 32'(a_timed_out), 32'd0);
        checkOutput("t2_cycle", 32'(a_cycle_count), 32'd22);

        // Watchdog with no HALT.
        doReset();
        for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("t3_pre_halt", 32'(a_halt), 32'd0);
        checkOutput("t3_pre_cycle", 32'(a_cycle_count), 32'd19);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("t3_halt", 32'(a_halt), 32'd1);
        checkOutput("t3_timed_out", 32'(a_timed_out), 32'd1);
        checkOutput("t3_freeze", 32'(a_freeze), 32'd1);
        checkOutput("t3_cycle", 32'(a_cycle_count), 32'd20);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'h0077, 1'b1);
        checkOutput("t3_frozen_cycle", 32'(a_cycle_count), 32'd20);
        checkOutput("t3_frozen_retire", 32'(a_retire_count), 32'd0);
        checkOutput("t3_frozen_pc", 32'(a_halt_pc), 32'd0);
        checkOutput("t3_still_timed_out", 32'(a_timed_out), 32'd1);

        // HALT on the same cycle the limit is reached: HALT wins.
        doReset();
        for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0ABC, 1'b0);
        checkOutput("t4_drain_timed_out", 32'(a_timed_out), 32'd0);
        checkOutput("t4_drain_halt", 32'(a_halt), 32'd0);
        checkOutput("t4_drain_freeze", 32'(a_freeze), 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("t4_done_halt", 32'(a_halt), 32'd1);
        checkOutput("t4_timed_out", 32'(a_timed_out), 32'd0);
        checkOutput("t4_cycle", 32'(a_cycle_count), 32'd21);
        checkOutput("t4_halt_pc", 32'(a_halt_pc), 32'h0ABC);
        checkOutput("t4_retire", 32'(a_retire_count), 32'd1);

        // Reset asserted mid-DRAIN, then a normal HALT.
        doReset();
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0030, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("t5_in_drain", 32'(a_freeze), 32'd1);
        doReset();
        checkCleared("t5_reset");
        applyStimulus(1'b1, 1'b1, 16'h0040, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("t5_done_halt", 32'(a_halt), 32'd1);
        checkOutput("t5_halt_pc", 32'(a_halt_pc), 32'h0040);
        checkOutput("t5_retire", 32'(a_retire_count), 32'd1);
        checkOutput("t5_cycle", 32'(a_cycle_count), 32'd2);

        // 4-bit counters saturate at 15.
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'h0004, 1'b0);
        checkOutput("t6_retire_mid", 32'(b_retire_count), 32'd10);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'h0008, 1'b0);
        checkOutput("t6_retire_sat", 32'(b_retire_count), 32'd15);
        checkOutput("t6_cycle_sat", 32'(b_cycle_count), 32'd15);
        checkOutput("t6_timed_out", 32'(b_timed_out), 32'd0);
        applyStimulus(1'b1, 1'b1, 16'h0099, 1'b1);
        checkOutput("t6_retire_hold", 32'(b_retire_count), 32'd15);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("t6_done_halt", 32'(b_halt), 32'd1);
        checkOutput("t6_halt_pc", 32'(b_halt_pc), 32'h0099);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
